obstaculo_sched: RTL

- Scheduler/controller for the cactus ("arbol") sprite renderers in the T-rex game.
- Owns NUM_OBS obstacle slots. Spawns obstacles at pseudo-random frame gaps and scrolls them left once per video frame.
- Drives posx/posy/enable for each sprite instance.
- Arbitrates the sprites' pixel outputs into one registered RGB/data stream for the VGA mixer.
- Tracks game state (idle/run/over), speed and score.

---
 rtl/obstaculo_sched.sv | 330 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/obstaculo_sched.sv
// obstaculo_sched: cactus obstacle scheduler for the T-rex game.
// Owns NUM_OBS sprite slots, spawns them at pseudo-random frame gaps,
// scrolls them left once per video frame, arbitrates their pixels into a
// single registered stream and tracks game state, speed and score.
// Optional build macro: SCORE_BCD_EN (score as 4 packed BCD digits).
//
// Pixel stream: data qualifies red/green/blue one cycle after sprite_data.
// There is no ready/backpressure; the mixer consumes the stream every cycle.
module obstaculo_sched #(
    parameter int NUM_OBS       = 3,
    parameter int SPRITE_W      = 20,
    parameter int SPRITE_H      = 20,
    parameter int SCREEN_W      = 640,
    parameter int GROUND_Y      = 400,
    parameter int FRAME_LINE    = 480,
    parameter int SPEED_INIT    = 2,
    parameter int SPEED_MAX     = 8,
    parameter int SPEED_STEP    = 256,
    parameter int GAP_MIN       = 40,
    parameter int GAP_RAND_MASK = 63
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   collision,
    input  logic [9:0]             vcount,
    input  logic [NUM_OBS-1:0]     sprite_data,
    input  logic [8*NUM_OBS-1:0]   sprite_rgb,
    output logic [NUM_OBS-1:0]     obs_enable,
    output logic [10*NUM_OBS-1:0]  obs_posx,
    output logic [9:0]             obs_posy,
    output logic [2:0]             red,
    output logic [2:0]             green,
    output logic [1:0]             blue,
    output logic                   data,
    output logic [1:0]             state,
    output logic [3:0]             speed,
    output logic [15:0]            score
);

    localparam int LOG_STEP = $clog2(SPEED_STEP);
    localparam int GAP_W    = $clog2(GAP_MIN + GAP_RAND_MASK + 1);

    localparam logic [9:0]       POSX_SPAWN = 10'(SCREEN_W);
    localparam logic [9:0]       POSY       = 10'(GROUND_Y - SPRITE_H);
    localparam logic [9:0]       LINE_END   = 10'(FRAME_LINE);
    localparam logic [3:0]       SPD_INIT   = 4'(SPEED_INIT);
    localparam logic [3:0]       SPD_MAX    = 4'(SPEED_MAX);
    localparam logic [GAP_W-1:0] GAP_BASE   = GAP_W'(GAP_MIN);
    localparam logic [7:0]       GAP_MASK   = 8'(GAP_RAND_MASK);
    localparam logic [7:0]       LFSR_SEED  = 8'hA5;

    // Reject parameter sets the slot/speed logic cannot honour.
    if (SPRITE_W < 1 || SPRITE_W > SCREEN_W || SPEED_STEP < 2 ||
        (SPEED_STEP & (SPEED_STEP - 1)) != 0) begin : g_bad_params
        $error("obstaculo_sched: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_OVER = 2'b10
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_clear;
    logic               w_run_tick;

    logic               r_prev_eq;
    logic               w_at_line;
    logic               w_tick;
    logic [7:0]         r_lfsr;

    logic [NUM_OBS-1:0] r_en;
    logic [9:0]         r_posx [NUM_OBS];
    logic [GAP_W-1:0]   r_gap;
    logic [3:0]         r_speed;
    logic [15:0]        r_score;

    logic [NUM_OBS-1:0] w_en_ret;
    logic [9:0]         w_posx_ret [NUM_OBS];
    logic [NUM_OBS-1:0] w_en_nxt;
    logic [9:0]         w_posx_nxt [NUM_OBS];
    logic               w_spawned;
    logic [GAP_W-1:0]   w_gap_nxt;
    logic [15:0]        w_score_nxt;
    logic               w_speed_step;
    logic [3:0]         w_speed_nxt;

    logic               w_pix_valid;
    logic [7:0]         w_pix_rgb;
    logic               r_data;
    logic [7:0]         r_rgb;

    // ------------------------------------------------------------------
    // Frame tick: one pulse on the first cycle vcount sits on FRAME_LINE.
    // ------------------------------------------------------------------
    assign w_at_line = (vcount == LINE_END);
    assign w_tick    = w_at_line & ~r_prev_eq;

    // Remember whether the previous cycle was already on the frame line.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_prev_eq <= 1'b0;
        end else begin
            r_prev_eq <= w_at_line;
        end
    end

    // Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4) for spawn gaps.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    // ------------------------------------------------------------------
    // Game FSM
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the two datapath strobes: full clear and frame update.
    // A collision in RUN wins over the tick, so the hit frame never scrolls.
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_run_tick  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_clear     = 1'b1;
                end
            end
            S_RUN: begin
                if (collision) begin
                    w_state_nxt = S_OVER;
                end else if (w_tick) begin
                    w_run_tick = 1'b1;
                end
            end
            S_OVER: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_clear     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Slot update for one frame: retire/scroll first, then spawn, so a
    // slot retired this frame is already eligible for the spawn.
    // ------------------------------------------------------------------
    // Retire slots that would scroll past x=0, move the rest left.
    always_comb begin
        w_en_ret = r_en;
        for (int i = 0; i < NUM_OBS; i++) begin
            w_posx_ret[i] = r_posx[i];
            if (r_en[i]) begin
                if (r_posx[i] < {6'd0, r_speed}) begin
                    w_en_ret[i]   = 1'b0;
                    w_posx_ret[i] = POSX_SPAWN;
                end else begin
                    w_posx_ret[i] = r_posx[i] - {6'd0, r_speed};
                end
            end
        end
    end

    // Spawn into the lowest free slot when the gap has expired; with no free
    // slot the gap parks at zero and the spawn retries next frame.
    always_comb begin
        w_en_nxt  = w_en_ret;
        w_spawned = 1'b0;
        for (int i = 0; i < NUM_OBS; i++) begin
            w_posx_nxt[i] = w_posx_ret[i];
        end
        if (r_gap == '0) begin
            for (int i = 0; i < NUM_OBS; i++) begin
                if (!w_spawned && !w_en_ret[i]) begin
                    w_en_nxt[i]   = 1'b1;
                    w_posx_nxt[i] = POSX_SPAWN;
                    w_spawned     = 1'b1;
                end
            end
        end
        if (r_gap != '0) begin
            w_gap_nxt = r_gap - GAP_W'(1);
        end else if (w_spawned) begin
            w_gap_nxt = GAP_BASE + GAP_W'(r_lfsr & GAP_MASK);
        end else begin
            w_gap_nxt = '0;
        end
    end

    // ------------------------------------------------------------------
    // Score and speed-step source
    // ------------------------------------------------------------------
`ifdef SCORE_BCD_EN
    logic [LOG_STEP-1:0] r_step_cnt;
    logic [LOG_STEP-1:0] w_step_cnt_nxt;

    // Add one to a 4-digit packed BCD value with decimal carries.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] res;
        logic        carry;
        res   = v;
        carry = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (carry) begin
                if (v[4*d +: 4] == 4'd9) begin
                    res[4*d +: 4] = 4'd0;
                end else begin
                    res[4*d +: 4] = v[4*d +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
        return res;
    endfunction

    assign w_score_nxt    = (r_score == 16'h9999) ? r_score : bcd_inc(r_score);
    assign w_step_cnt_nxt = r_step_cnt + LOG_STEP'(1);
    assign w_speed_step   = (w_step_cnt_nxt == '0);

    // Binary frame counter that paces speed steps independently of BCD score.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_step_cnt <= '0;
        end else if (w_clear) begin
            r_step_cnt <= '0;
        end else if (w_run_tick) begin
            r_step_cnt <= w_step_cnt_nxt;
        end
    end
`else
    assign w_score_nxt  = (r_score == 16'hFFFF) ? r_score : r_score + 16'd1;
    assign w_speed_step = (r_score != 16'hFFFF) && (w_score_nxt[LOG_STEP-1:0] == '0);
`endif

    assign w_speed_nxt = (w_speed_step && (r_speed < SPD_MAX)) ? r_speed + 4'd1 : r_speed;

    // Slot, gap, score and speed registers: cleared on (re)start, updated once
    // per frame in RUN, frozen otherwise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_en    <= '0;
            r_gap   <= GAP_BASE;
            r_speed <= SPD_INIT;
            r_score <= '0;
            for (int i = 0; i < NUM_OBS; i++) begin
                r_posx[i] <= POSX_SPAWN;
            end
        end else if (w_clear) begin
            r_en    <= '0;
            r_gap   <= GAP_BASE;
            r_speed <= SPD_INIT;
            r_score <= '0;
            for (int i = 0; i < NUM_OBS; i++) begin
                r_posx[i] <= POSX_SPAWN;
            end
        end else if (w_run_tick) begin
            r_en    <= w_en_nxt;
            r_gap   <= w_gap_nxt;
            r_speed <= w_speed_nxt;
            r_score <= w_score_nxt;
            for (int i = 0; i < NUM_OBS; i++) begin
                r_posx[i] <= w_posx_nxt[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Pixel arbiter: lowest-index valid sprite wins, output registered.
    // ------------------------------------------------------------------
    // Priority select; scanning downward leaves the lowest index in place.
    always_comb begin
        w_pix_valid = 1'b0;
        w_pix_rgb   = 8'd0;
        for (int i = NUM_OBS - 1; i >= 0; i--) begin
            if (sprite_data[i]) begin
                w_pix_valid = 1'b1;
                w_pix_rgb   = sprite_rgb[8*i +: 8];
            end
        end
    end

    // Register the arbitrated pixel for the VGA mixer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= 1'b0;
            r_rgb  <= 8'd0;
        end else begin
            r_data <= w_pix_valid;
            r_rgb  <= w_pix_rgb;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_OBS; gi++) begin : g_posx
        assign obs_posx[10*gi +: 10] = r_posx[gi];
    end

    assign obs_enable = r_en;
    assign obs_posy   = POSY;
    assign red        = r_rgb[7:5];
    assign green      = r_rgb[4:2];
    assign blue       = r_rgb[1:0];
    assign data       = r_data;
    assign state      = r_state;
    assign speed      = r_speed;
    assign score      = r_score;

endmodule
